// File: rtl/stack_sequencer.sv
// ---------------------------------------------------------------------------
// stack_sequencer
// Sequences PUSH / POP / CALL / RET operations onto a 256-entry stack held in
// an external scratch RAM. The stack pointer itself lives outside this block
// and is moved through the SP_LD / SP_INCR / SP_DECR strobes. The stack grows
// downward: a push writes at SP-1 and then decrements SP. A pop reads at SP
// and then increments SP.
//
// Ports
//   CLK, RST            rising-edge clock, synchronous active-high reset
//   START, OP           operation request (sampled in IDLE only) and opcode:
//                       00 PUSH, 01 POP, 10 CALL, 11 RET
//   REG_DATA, PC_DATA   PUSH operand (8b, zero-extended) / CALL operand (10b)
//   INIT, INIT_VAL      stack-pointer load request and value (IDLE only)
//   SP_VAL              current stack pointer
//   SCR_DATA_OUT        scratch RAM read data, one cycle after the address
//   SP_LD/INCR/DECR     stack pointer strobes; SP_DATA_IN is the load value
//   SCR_ADDR, SCR_DATA_IN, SCR_WE   scratch RAM address / write data / enable
//   RESULT, RESULT_VALID            popped value and its update flag
//   BUSY, DONE, FAULT               status, completion and reject pulses
//   OVF, UNF                        sticky overflow / underflow flags
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting; INIT loads SP, START launches an operation
// PUSH_WR  | write latched data at SP-1, decrement SP
// POP_RD   | present SP as read address, increment SP
// POP_WAIT | RAM data valid; capture it into RESULT
// DONE_ST  | one-cycle DONE (plus RESULT_VALID for POP/RET)
// FAULT_ST | one-cycle FAULT; rejected operation, nothing touched
// ---------------------------------------------------------------------------
module stack_sequencer (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [1:0] OP,
   input  logic [7:0] REG_DATA,
   input  logic [9:0] PC_DATA,
   input  logic       INIT,
   input  logic [7:0] INIT_VAL,
   input  logic [7:0] SP_VAL,
   input  logic [9:0] SCR_DATA_OUT,
   output logic       SP_LD,
   output logic       SP_INCR,
   output logic       SP_DECR,
   output logic [7:0] SP_DATA_IN,
   output logic [7:0] SCR_ADDR,
   output logic [9:0] SCR_DATA_IN,
   output logic       SCR_WE,
   output logic [9:0] RESULT,
   output logic       RESULT_VALID,
   output logic       BUSY,
   output logic       DONE,
   output logic       FAULT,
   output logic       OVF,
   output logic       UNF
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PUSH_WR  = 3'd1,
      POP_RD   = 3'd2,
      POP_WAIT = 3'd3,
      DONE_ST  = 3'd4,
      FAULT_ST = 3'd5
   } state_t;

   state_t     state_q, state_d;
   logic [8:0] depth_q;
   logic [1:0] op_q;
   logic [9:0] data_q;
   logic [9:0] result_q;
   logic       ovf_q, unf_q;

   logic       is_full, is_empty;
   logic       sp_ld_raw, sp_incr_raw, sp_decr_raw, scr_we_raw;

   assign is_full  = (depth_q == 9'd256);
   assign is_empty = (depth_q == 9'd0);

   always_ff @(posedge CLK) begin
      if (RST) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // OP[0] set means the operation removes an entry (POP / RET).
   always_comb begin
      state_d      = state_q;
      sp_ld_raw    = 1'b0;
      sp_incr_raw  = 1'b0;
      sp_decr_raw  = 1'b0;
      scr_we_raw   = 1'b0;
      SCR_ADDR     = SP_VAL - 8'd1;
      DONE         = 1'b0;
      FAULT        = 1'b0;
      RESULT_VALID = 1'b0;
      case (state_q)
         IDLE: begin
            if (INIT) begin
               sp_ld_raw = 1'b1;
            end else if (START) begin
               if (OP[0]) state_d = is_empty ? FAULT_ST : POP_RD;
               else       state_d = is_full  ? FAULT_ST : PUSH_WR;
            end
         end
         PUSH_WR: begin
            scr_we_raw  = 1'b1;
            sp_decr_raw = 1'b1;
            state_d     = DONE_ST;
         end
         POP_RD: begin
            SCR_ADDR    = SP_VAL;
            sp_incr_raw = 1'b1;
            state_d     = POP_WAIT;
         end
         POP_WAIT: begin
            state_d = DONE_ST;
         end
         DONE_ST: begin
            DONE         = 1'b1;
            RESULT_VALID = op_q[0];
            state_d      = IDLE;
         end
         FAULT_ST: begin
            FAULT   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A cycle with RST high must not move SP or write RAM, even mid-operation.
   assign SP_LD       = sp_ld_raw   & ~RST;
   assign SP_INCR     = sp_incr_raw & ~RST;
   assign SP_DECR     = sp_decr_raw & ~RST;
   assign SCR_WE      = scr_we_raw  & ~RST;
   assign SP_DATA_IN  = INIT_VAL;
   assign SCR_DATA_IN = data_q;
   assign BUSY        = (state_q != IDLE);
   assign RESULT      = result_q;
   assign OVF         = ovf_q;
   assign UNF         = unf_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         depth_q  <= 9'd0;
         op_q     <= 2'b00;
         data_q   <= 10'd0;
         result_q <= 10'd0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (INIT) begin
                  depth_q <= 9'd0;
                  ovf_q   <= 1'b0;
                  unf_q   <= 1'b0;
               end else if (START) begin
                  op_q   <= OP;
                  data_q <= OP[1] ? PC_DATA : {2'b00, REG_DATA};
                  if (OP[0] && is_empty)  unf_q <= 1'b1;
                  if (!OP[0] && is_full)  ovf_q <= 1'b1;
               end
            end
            PUSH_WR:  depth_q  <= depth_q + 9'd1;
            POP_RD:   depth_q  <= depth_q - 9'd1;
            POP_WAIT: result_q <= SCR_DATA_OUT;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_sequencer.sv
module tb_stack_sequencer;

   logic       CLK = 1'b0;
   logic       RST, START, INIT;
   logic [1:0] OP;
   logic [7:0] REG_DATA, INIT_VAL, SP_VAL;
   logic [9:0] PC_DATA, SCR_DATA_OUT;
   logic       SP_LD, SP_INCR, SP_DECR, SCR_WE;
   logic [7:0] SP_DATA_IN, SCR_ADDR;
   logic [9:0] SCR_DATA_IN, RESULT;
   logic       RESULT_VALID, BUSY, DONE, FAULT, OVF, UNF;

   stack_sequencer dut (
      .CLK(CLK), .RST(RST), .START(START), .OP(OP), .REG_DATA(REG_DATA),
      .PC_DATA(PC_DATA), .INIT(INIT), .INIT_VAL(INIT_VAL), .SP_VAL(SP_VAL),
      .SCR_DATA_OUT(SCR_DATA_OUT), .SP_LD(SP_LD), .SP_INCR(SP_INCR),
      .SP_DECR(SP_DECR), .SP_DATA_IN(SP_DATA_IN), .SCR_ADDR(SCR_ADDR),
      .SCR_DATA_IN(SCR_DATA_IN), .SCR_WE(SCR_WE), .RESULT(RESULT),
      .RESULT_VALID(RESULT_VALID), .BUSY(BUSY), .DONE(DONE), .FAULT(FAULT),
      .OVF(OVF), .UNF(UNF)
   );

   always #5 CLK = ~CLK;

   // environment: external stack pointer register and scratch RAM
   logic [7:0] sp_reg = 8'h00;
   logic [9:0] scr_q;
   logic [9:0] ram [256];
   always @(posedge CLK) begin
      if (SP_LD)        sp_reg <= SP_DATA_IN;
      else if (SP_INCR) sp_reg <= sp_reg + 8'd1;
      else if (SP_DECR) sp_reg <= sp_reg - 8'd1;
      if (SCR_WE) ram[SCR_ADDR] <= SCR_DATA_IN;
      scr_q <= ram[SCR_ADDR];
   end
   assign SP_VAL       = sp_reg;
   assign SCR_DATA_OUT = scr_q;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // scoreboard
   typedef struct { bit fault; bit pop; logic [9:0] result; logic [7:0] sp; int due; } ev_t;
   typedef struct { logic [7:0] addr; logic [9:0] data; } wr_t;
   ev_t        evq[$];
   wr_t        wq[$];
   logic [7:0] rq[$];

   // reference model
   logic [7:0] m_sp;
   logic [9:0] m_mem [256];
   bit         m_ovf, m_unf;

   always @(negedge CLK) begin
      if (RST === 1'b0) begin
         if (SP_LD || SP_INCR || SP_DECR || SCR_WE) begin
            check("one_strobe", 32'($countones({SP_LD, SP_INCR, SP_DECR})), 1);
            check("we_with_decr", SCR_WE, SP_DECR);
         end
         if (SCR_WE) begin
            if (wq.size() == 0) check("unexpected_write", SCR_WE, 0);
            else begin
               wr_t w;
               w = wq.pop_front();
               check("wr_addr", SCR_ADDR, w.addr);
               check("wr_data", SCR_DATA_IN, w.data);
            end
         end
         if (SP_INCR) begin
            if (rq.size() == 0) check("unexpected_read", SP_INCR, 0);
            else check("rd_addr", SCR_ADDR, rq.pop_front());
         end
         if (DONE || FAULT) begin
            if (evq.size() == 0) check("unexpected_event", {DONE, FAULT}, 0);
            else begin
               ev_t e;
               e = evq.pop_front();
               check("fault", FAULT, e.fault);
               check("done", DONE, !e.fault);
               check("result_valid", RESULT_VALID, e.pop && !e.fault);
               if (e.pop && !e.fault) check("result", RESULT, e.result);
               check("latency", cyc, e.due);
               check("sp_after", SP_VAL, e.sp);
            end
         end
      end
   end

   // Called at posedge+2; returns at posedge+2 with the sequencer back in IDLE.
   task automatic issue(input logic [1:0] op, input logic [7:0] r, input logic [9:0] pc,
                        input bit fault, input logic [9:0] res, input bit poke = 1'b0);
      ev_t        e;
      logic [9:0] d;
      d = op[1] ? pc : {2'b00, r};
      e.fault  = fault;
      e.pop    = op[0];
      e.result = res;
      if (fault) begin
         e.due = cyc + 1;
         if (op[0]) m_unf = 1'b1;
         else       m_ovf = 1'b1;
      end else if (!op[0]) begin
         m_sp = m_sp - 8'd1;
         m_mem[m_sp] = d;
         wq.push_back('{addr: m_sp, data: d});
         e.due = cyc + 2;
      end else begin
         rq.push_back(m_sp);
         m_sp  = m_sp + 8'd1;
         e.due = cyc + 3;
      end
      e.sp = m_sp;
      evq.push_back(e);
      START = 1'b1; OP = op; REG_DATA = r; PC_DATA = pc;
      @(posedge CLK); #2;
      if (poke) begin
         check("busy_during_poke", BUSY, 1);
         OP = 2'b01;
         @(posedge CLK); #2;
      end
      START = 1'b0;
      for (int k = 0; k < 12 && evq.size() != 0; k++) @(posedge CLK);
      #2;
      if (evq.size() != 0) begin
         n_vec++; n_err++;
         $display("FAIL timeout: %0d events outstanding, expected 0", evq.size());
         evq.delete();
      end
   endtask

   task automatic do_init(input logic [7:0] v);
      INIT = 1'b1; INIT_VAL = v;
      #1;
      check("init_sp_ld", SP_LD, 1);
      check("init_sp_data", SP_DATA_IN, v);
      @(posedge CLK); #2;
      INIT = 1'b0;
      m_sp = v; m_ovf = 1'b0; m_unf = 1'b0;
   endtask

   typedef struct { logic [1:0] op; logic [7:0] r; logic [9:0] pc; bit fault; logic [9:0] res; } vec_t;
   vec_t tbl [9];

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{2'b00, 8'hA5, 10'h000, 1'b0, 10'h000};
      tbl[1] = '{2'b10, 8'h00, 10'h3C7, 1'b0, 10'h000};
      tbl[2] = '{2'b11, 8'h00, 10'h000, 1'b0, 10'h3C7};
      tbl[3] = '{2'b01, 8'h00, 10'h000, 1'b0, 10'h0A5};
      tbl[4] = '{2'b01, 8'h00, 10'h000, 1'b1, 10'h000};
      tbl[5] = '{2'b10, 8'h00, 10'h155, 1'b0, 10'h000};
      tbl[6] = '{2'b00, 8'h7E, 10'h000, 1'b0, 10'h000};
      tbl[7] = '{2'b01, 8'h00, 10'h000, 1'b0, 10'h07E};
      tbl[8] = '{2'b11, 8'h00, 10'h000, 1'b0, 10'h155};

      RST = 1'b1; START = 1'b0; INIT = 1'b0; OP = 2'b00;
      REG_DATA = 8'h00; PC_DATA = 10'h000; INIT_VAL = 8'h00;
      m_sp = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
      repeat (3) @(posedge CLK);
      #2 RST = 1'b0;
      #1;
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_fault", FAULT, 0);
      check("rst_rvalid", RESULT_VALID, 0);
      check("rst_result", RESULT, 0);
      check("rst_ovf", OVF, 0);
      check("rst_unf", UNF, 0);
      check("rst_strobes", {SP_LD, SP_INCR, SP_DECR, SCR_WE}, 0);
      @(posedge CLK); #2;

      // table: push/call/ret/pop, underflow, sticky UNF
      do_init(8'h00);
      for (int i = 0; i < 9; i++) begin
         issue(tbl[i].op, tbl[i].r, tbl[i].pc, tbl[i].fault, tbl[i].res);
         if (i == 5) check("result_hold", RESULT, 10'h0A5);
      end
      check("unf_sticky", UNF, m_unf);
      check("ovf_clear", OVF, m_ovf);
      do_init(8'h40);
      check("unf_cleared_by_init", UNF, 0);

      // INIT and START together: only the load happens
      INIT = 1'b1; INIT_VAL = 8'h80; START = 1'b1; OP = 2'b00; REG_DATA = 8'h33;
      #1;
      check("init_start_sp_ld", SP_LD, 1);
      @(posedge CLK); #2;
      INIT = 1'b0; START = 1'b0;
      m_sp = 8'h80;
      check("init_start_busy", BUSY, 0);
      repeat (3) @(posedge CLK);
      #2;
      check("init_start_sp", SP_VAL, m_sp);
      check("init_start_idle", BUSY, 0);

      // START held while busy (with a different OP) is ignored
      issue(2'b00, 8'h5C, 10'h000, 1'b0, 10'h000, 1'b1);
      repeat (4) @(posedge CLK);
      #2;
      check("busy_start_ignored", BUSY, 0);
      issue(2'b01, 8'h00, 10'h000, 1'b0, 10'h05C);

      // fill to 256, then overflow
      do_init(8'h00);
      for (int i = 0; i < 256; i++) issue(2'b00, 8'(i) ^ 8'h5A, 10'h000, 1'b0, 10'h000);
      issue(2'b00, 8'h11, 10'h000, 1'b1, 10'h000);
      check("ovf_set", OVF, m_ovf);
      check("ovf_sp_unchanged", SP_VAL, 8'h00);
      issue(2'b01, 8'h00, 10'h000, 1'b0, 10'h0A5);
      check("ovf_sticky", OVF, 1);

      // RST during POP_WAIT aborts the pop
      START = 1'b1; OP = 2'b01;
      rq.push_back(m_sp);
      m_sp = m_sp + 8'd1;
      @(posedge CLK); #2;
      START = 1'b0;
      @(posedge CLK); #2;
      check("pop_wait_busy", BUSY, 1);
      RST = 1'b1;
      @(posedge CLK); #2;
      RST = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0;
      #1;
      check("abort_busy", BUSY, 0);
      check("abort_done", DONE, 0);
      check("abort_rvalid", RESULT_VALID, 0);
      check("abort_result", RESULT, 0);
      check("abort_ovf", OVF, 0);
      check("abort_strobes", {SP_LD, SP_INCR, SP_DECR, SCR_WE}, 0);
      @(posedge CLK); #2;
      issue(2'b11, 8'h00, 10'h000, 1'b1, 10'h000);
      check("abort_depth_zero_unf", UNF, m_unf);
      check("abort_sp", SP_VAL, m_sp);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
